// File: rtl/heartbeat_monitor.sv
// Receive-side heartbeat checker: synchronizes the pad heartbeat, measures the
// rising-edge interval and tracks ACQUIRE/LOCKED/LOST with an error counter.
module heartbeat_monitor #(
  parameter int N          = 8,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hb_in,
  output logic         locked,
  output logic         lost,
  output logic [N+1:0] period,
  output logic         period_valid,
  output logic [7:0]   err_count
);

  localparam int P  = 1 << N;
  localparam int CW = N + 2;
  localparam logic [CW-1:0] C_LO  = CW'(P - TOL);
  localparam logic [CW-1:0] C_HI  = CW'(P + TOL);
  localparam logic [CW-1:0] C_TO  = CW'(P + TOL + 1);
  localparam logic [CW-1:0] C_MAX = '1;
  localparam logic [3:0]    G_LAST = 4'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_LOCKED,
    ST_LOST
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic [CW-1:0] r_cnt;
  logic          r_seen;
  logic [CW-1:0] r_period;
  logic          r_period_valid;
  logic [3:0]    r_gcnt;
  logic [7:0]    r_err;

  logic w_rise;
  logic w_meas;
  logic w_in_win;
  logic w_good;
  logic w_bad;
  logic w_timeout;
  logic w_miss;
  logic w_err_inc;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= hb_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_meas    = w_rise & r_seen;
  assign w_in_win  = (r_cnt >= C_LO) && (r_cnt <= C_HI);
  assign w_good    = w_meas & w_in_win;
  assign w_bad     = w_meas & ~w_in_win;
  // A rise on the threshold cycle is a late pulse, not a timeout.
  assign w_timeout = r_seen & ~w_rise & (r_cnt == C_TO);
  assign w_miss    = w_bad | w_timeout;

  // Saturation keeps the timeout compare from matching twice in one gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_seen <= 1'b0;
    end else begin
      if (w_rise) begin
        r_cnt  <= CW'(1);
        r_seen <= 1'b1;
      end else if (r_cnt != C_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= w_meas;
      if (w_meas) begin
        r_period <= r_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gcnt <= '0;
    end else if (w_miss) begin
      r_gcnt <= '0;
    end else if (w_good && (r_gcnt != 4'hF)) begin
      r_gcnt <= r_gcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACQUIRE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err_inc    = 1'b0;
    case (r_state)
      ST_ACQUIRE, ST_LOST: begin
        if (w_good && (r_gcnt == G_LAST)) begin
          w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_miss) begin
          w_state_next = ST_LOST;
          w_err_inc    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_ACQUIRE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= '0;
    end else if (w_err_inc && (r_err != 8'hFF)) begin
      r_err <= r_err + 8'd1;
    end
  end

  assign locked       = (r_state == ST_LOCKED);
  assign lost         = (r_state == ST_LOST);
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign err_count    = r_err;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Bench for heartbeat_monitor: pulse table, hand-written corner sequences and
// random pulse trains checked against a timestamp-based reference model.
module tb_heartbeat_monitor;

  localparam int N   = 4;
  localparam int TOL = 1;
  localparam int LC  = 3;
  localparam int P   = 1 << N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         hb_in = 1'b0;
  logic         locked;
  logic         lost;
  logic [N+1:0] period;
  logic         period_valid;
  logic [7:0]   err_count;

  heartbeat_monitor #(.N(N), .TOL(TOL), .LOCK_COUNT(LC)) dut (
    .clk          (clk),
    .reset        (reset),
    .hb_in        (hb_in),
    .locked       (locked),
    .lost         (lost),
    .period       (period),
    .period_valid (period_valid),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit lost;
    int period;
    bit pv;
    int err;
  } obs_t;

  typedef struct {
    int gap;
    int width;
    bit pv;
    int period;
    bit locked;
    bit lost;
    int err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state, kept in pad time (cycle of each driven hb value).
  int   m_cyc;
  int   m_last;
  bit   m_prev;
  bit   m_locked;
  bit   m_lost;
  int   m_run;
  int   m_period;
  int   m_err;
  obs_t pipe[$];

  bit d_locked;
  bit d_lost;
  int d_period;
  bit d_pv;
  int d_err;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    obs_t z;
    z = '{default: 0};
    m_last = -1;
    m_prev = 1'b0;
    m_locked = 1'b0;
    m_lost = 1'b0;
    m_run = 0;
    m_period = 0;
    m_err = 0;
    pipe.delete();
    repeat (3) pipe.push_back(z);
  endtask

  task automatic model_step(input bit h, output obs_t o);
    bit rise;
    bit good;
    bit miss;
    int iv;
    good = 1'b0;
    miss = 1'b0;
    o.pv = 1'b0;
    rise = h && !m_prev;
    m_prev = h;
    if (rise) begin
      if (m_last >= 0) begin
        iv = m_cyc - m_last;
        m_period = iv;
        o.pv = 1'b1;
        if (iv >= P - TOL && iv <= P + TOL) good = 1'b1;
        else miss = 1'b1;
      end
      m_last = m_cyc;
    end else if (m_last >= 0 && (m_cyc - m_last) == P + TOL + 1) begin
      miss = 1'b1;
    end
    if (good) begin
      m_run++;
      if (!m_locked && m_run >= LC) begin
        m_locked = 1'b1;
        m_lost = 1'b0;
      end
    end
    if (miss) begin
      m_run = 0;
      if (m_locked) begin
        m_locked = 1'b0;
        m_lost = 1'b1;
        if (m_err < 255) m_err++;
      end
    end
    o.locked = m_locked;
    o.lost = m_lost;
    o.period = m_period;
    o.err = m_err;
  endtask

  // One clock: sample and check the edge just taken, then drive the next inputs.
  task automatic tick(input bit h, input bit rst);
    obs_t e;
    obs_t o;
    @(posedge clk);
    #1;
    d_locked = locked;
    d_lost   = lost;
    d_period = int'(period);
    d_pv     = period_valid;
    d_err    = int'(err_count);
    e = pipe.pop_front();
    total++;
    if (d_locked != e.locked || d_lost != e.lost || d_period != e.period ||
        d_pv != e.pv || d_err != e.err) begin
      bad++;
      $display("FAIL model cyc=%0d got L=%0b l=%0b p=%0d v=%0b e=%0d expected L=%0b l=%0b p=%0d v=%0b e=%0d",
               m_cyc, d_locked, d_lost, d_period, d_pv, d_err,
               e.locked, e.lost, e.period, e.pv, e.err);
    end
    hb_in = h;
    reset = rst;
    m_cyc++;
    if (rst) begin
      model_reset();
    end else begin
      model_step(h, o);
      pipe.push_back(o);
    end
  endtask

  vec_t vt[17];
  int   found;
  bit   ever_locked;

  initial begin
    vt[0]  = '{16, 1, 0,  0, 0, 0, 0};
    vt[1]  = '{16, 1, 1, 16, 0, 0, 0};
    vt[2]  = '{16, 1, 1, 16, 0, 0, 0};
    vt[3]  = '{20, 1, 1, 16, 1, 0, 0};
    vt[4]  = '{16, 1, 1, 20, 0, 1, 1};
    vt[5]  = '{15, 1, 1, 16, 0, 1, 1};
    vt[6]  = '{17, 1, 1, 15, 0, 1, 1};
    vt[7]  = '{14, 1, 1, 17, 1, 0, 1};
    vt[8]  = '{16, 1, 1, 14, 0, 1, 2};
    vt[9]  = '{16, 1, 1, 16, 0, 1, 2};
    vt[10] = '{16, 1, 1, 16, 0, 1, 2};
    vt[11] = '{18, 1, 1, 16, 1, 0, 2};
    vt[12] = '{16, 5, 1, 18, 0, 1, 3};
    vt[13] = '{16, 5, 1, 16, 0, 1, 3};
    vt[14] = '{16, 5, 1, 16, 0, 1, 3};
    vt[15] = '{16, 5, 1, 16, 1, 0, 3};
    vt[16] = '{16, 1, 1, 16, 1, 0, 3};

    m_cyc = 0;
    model_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("reset_locked", d_locked, 0);
    chk("reset_lost", d_lost, 0);
    chk("reset_period", d_period, 0);
    chk("reset_pv", d_pv, 0);
    chk("reset_err", d_err, 0);

    // Pulse table: expectations sampled three cycles after each pad rise.
    for (int k = 0; k < 17; k++) begin
      tick(1'b1, 1'b0);
      for (int i = 1; i < vt[k].gap; i++) begin
        tick(i < vt[k].width, 1'b0);
        if (i == 3) begin
          chk($sformatf("vec%0d_pv", k), d_pv, vt[k].pv);
          chk($sformatf("vec%0d_period", k), d_period, vt[k].period);
          chk($sformatf("vec%0d_locked", k), d_locked, vt[k].locked);
          chk($sformatf("vec%0d_lost", k), d_lost, vt[k].lost);
          chk($sformatf("vec%0d_err", k), d_err, vt[k].err);
          $display("vec %0d: gap=%0d width=%0d period=%0d locked=%0b lost=%0b err=%0d",
                   k, vt[k].gap, vt[k].width, d_period, d_locked, d_lost, d_err);
        end
      end
    end

    // Reset while locked with err_count=3, then a fresh four-pulse relock.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("midlock_reset_locked", d_locked, 0);
    chk("midlock_reset_lost", d_lost, 0);
    chk("midlock_reset_period", d_period, 0);
    chk("midlock_reset_err", d_err, 0);
    $display("mid-lock reset: locked=%0b lost=%0b err=%0d", d_locked, d_lost, d_err);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0);
      for (int i = 1; i < P; i++) begin
        tick(1'b0, 1'b0);
        if (i == 3) chk($sformatf("relock_pulse%0d_locked", k), d_locked, 0);
      end
    end

    // Fourth pulse locks; then hb_in stays low until well past counter saturation.
    found = -1;
    tick(1'b1, 1'b0);
    for (int n = 1; n <= 100; n++) begin
      tick(1'b0, 1'b0);
      if (n == 3) chk("relock_pulse3_locked", d_locked, 1);
      if (d_lost && found < 0) found = n;
    end
    chk("timeout_latency", found, P + TOL + 1 + 3);
    chk("timeout_lost", d_lost, 1);
    chk("timeout_err_once", d_err, 1);
    $display("timeout: lost after %0d cycles, err=%0d", found, d_err);

    // Period-2 toggling never locks.
    ever_locked = 1'b0;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      tick(i[0] == 1'b0, 1'b0);
      if (d_locked) ever_locked = 1'b1;
    end
    chk("toggle_never_locked", ever_locked, 0);
    chk("toggle_period", d_period, 2);
    chk("toggle_lost", d_lost, 0);
    $display("toggle: period=%0d locked_seen=%0b", d_period, ever_locked);

    // Random pulse trains near and far from the nominal period.
    tick(1'b0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      int gap;
      int width;
      if ($urandom_range(0, 9) < 6) gap = $urandom_range(P - TOL - 1, P + TOL + 1);
      else gap = $urandom_range(2, 60);
      width = $urandom_range(1, gap - 1);
      if ($urandom_range(0, 99) == 0) tick(1'b0, 1'b1);
      for (int i = 0; i < gap; i++) tick(i < width, 1'b0);
    end
    repeat (4) tick(1'b0, 1'b0);
    $display("random: final locked=%0b lost=%0b err=%0d", d_locked, d_lost, d_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
